// File: rtl/bbox_tracker_pkg.sv
// bbox_tracker_pkg
// Shared widths, FSM state type and empty-accumulator constants for the
// bounding-box tracker and its min/max accumulator.
package bbox_tracker_pkg;

    localparam int HC_W   = 11;
    localparam int VC_W   = 10;
    localparam int XO_W   = 12;
    localparam int YO_W   = 11;
    localparam int AREA_W = 21;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // An empty accumulator has min above any real coordinate and max below
    // it, so the first qualifying pixel overwrites both.
    localparam logic [HC_W-1:0]   X_EMPTY_MIN = '1;
    localparam logic [HC_W-1:0]   X_EMPTY_MAX = '0;
    localparam logic [VC_W-1:0]   Y_EMPTY_MIN = '1;
    localparam logic [VC_W-1:0]   Y_EMPTY_MAX = '0;
    localparam logic [AREA_W-1:0] AREA_MAX    = '1;

endpackage

// File: rtl/bbox_tracker_minmax_accum.sv
// bbox_tracker_minmax_accum
// Running min/max of one coordinate over a frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (to the empty state)
//   seed        : start a new frame; load value if hit, else the empty state
//   hit         : value belongs to the frame
//   value       : coordinate of the current pixel
//   value_min   : smallest hit coordinate so far
//   value_max   : largest hit coordinate so far
module bbox_tracker_minmax_accum #(
    parameter int           W         = 11,
    parameter logic [W-1:0] EMPTY_MIN = '1,
    parameter logic [W-1:0] EMPTY_MAX = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed,
    input  logic         hit,
    input  logic [W-1:0] value,
    output logic [W-1:0] value_min,
    output logic [W-1:0] value_max
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value_min <= EMPTY_MIN;
            value_max <= EMPTY_MAX;
        end else if (seed) begin
            value_min <= hit ? value : EMPTY_MIN;
            value_max <= hit ? value : EMPTY_MAX;
        end else if (hit) begin
            if (value < value_min) value_min <= value;
            if (value > value_max) value_max <= value;
        end
    end

endmodule

// File: rtl/bbox_tracker.sv
// bbox_tracker
// Accumulates the bounding box of set mask pixels over each frame and, at
// the next frame boundary, publishes it in centre/max form.
// Ports:
//   clk_in, rst_in  : pixel clock, synchronous active-high reset
//   valid_in        : hcount_in/vcount_in/mask_in valid this cycle
//   new_frame_in    : pulse with the first pixel of a frame
//   hcount_in       : pixel column
//   vcount_in       : pixel row
//   mask_in         : pixel belongs to the tracked object
//   x_out, y_out    : box centre, floor((min+max)/2)
//   xmax_out        : rightmost set column
//   ymax_out        : bottom set row
//   area_out        : set-pixel count of last published frame (saturating)
//   found_out       : last published frame reached MIN_PIXELS
//   valid_out       : one-cycle pulse when a result is published
module bbox_tracker
    import bbox_tracker_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int MIN_PIXELS = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    input  logic              new_frame_in,
    input  logic [HC_W-1:0]   hcount_in,
    input  logic [VC_W-1:0]   vcount_in,
    input  logic              mask_in,
    output logic [XO_W-1:0]   x_out,
    output logic [YO_W-1:0]   y_out,
    output logic [XO_W-1:0]   xmax_out,
    output logic [YO_W-1:0]   ymax_out,
    output logic [AREA_W-1:0] area_out,
    output logic              found_out,
    output logic              valid_out
);

    localparam logic [HC_W-1:0]   H_LIMIT   = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0]   V_LIMIT   = VC_W'(V_ACTIVE);
    localparam logic [AREA_W-1:0] MIN_LIMIT = AREA_W'(MIN_PIXELS);

    logic              valid_r, new_frame_r, mask_r;
    logic [HC_W-1:0]   hcount_r;
    logic [VC_W-1:0]   vcount_r;

    state_t            state, state_next;
    logic              qualifies, hit;
    logic [HC_W-1:0]   acc_xmin, acc_xmax;
    logic [VC_W-1:0]   acc_ymin, acc_ymax;
    logic [AREA_W-1:0] acc_count;

    logic              snap_valid;
    logic [HC_W-1:0]   snap_xmin, snap_xmax;
    logic [VC_W-1:0]   snap_ymin, snap_ymax;
    logic [AREA_W-1:0] snap_count;
    logic [XO_W-1:0]   x_sum;
    logic [YO_W-1:0]   y_sum;
    logic              snap_found;

    // Stage 0: register every input.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_r     <= 1'b0;
            new_frame_r <= 1'b0;
            mask_r      <= 1'b0;
            hcount_r    <= '0;
            vcount_r    <= '0;
        end else begin
            valid_r     <= valid_in;
            new_frame_r <= new_frame_in;
            mask_r      <= mask_in;
            hcount_r    <= hcount_in;
            vcount_r    <= vcount_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_frame_r) state_next = ACCUM;
            ACCUM:   state_next = ACCUM;
            default: state_next = IDLE;
        endcase
    end

    // A pixel arriving with new_frame seeds the new frame, even from IDLE.
    assign qualifies = valid_r && mask_r && (hcount_r < H_LIMIT) && (vcount_r < V_LIMIT);
    assign hit       = qualifies && (new_frame_r || (state == ACCUM));

    bbox_tracker_minmax_accum #(
        .W(HC_W), .EMPTY_MIN(X_EMPTY_MIN), .EMPTY_MAX(X_EMPTY_MAX)
    ) u_x_accum (
        .clk(clk_in), .rst(rst_in), .seed(new_frame_r), .hit(hit),
        .value(hcount_r), .value_min(acc_xmin), .value_max(acc_xmax)
    );

    bbox_tracker_minmax_accum #(
        .W(VC_W), .EMPTY_MIN(Y_EMPTY_MIN), .EMPTY_MAX(Y_EMPTY_MAX)
    ) u_y_accum (
        .clk(clk_in), .rst(rst_in), .seed(new_frame_r), .hit(hit),
        .value(vcount_r), .value_min(acc_ymin), .value_max(acc_ymax)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_count <= '0;
        end else if (new_frame_r) begin
            acc_count <= AREA_W'(hit);
        end else if (hit && (acc_count != AREA_MAX)) begin
            acc_count <= acc_count + 1'b1;
        end
    end

    // Snapshot the finished frame; the accumulators re-seed in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            snap_valid <= 1'b0;
            snap_xmin  <= '0;
            snap_xmax  <= '0;
            snap_ymin  <= '0;
            snap_ymax  <= '0;
            snap_count <= '0;
        end else begin
            snap_valid <= new_frame_r && (state == ACCUM);
            if (new_frame_r && (state == ACCUM)) begin
                snap_xmin  <= acc_xmin;
                snap_xmax  <= acc_xmax;
                snap_ymin  <= acc_ymin;
                snap_ymax  <= acc_ymax;
                snap_count <= acc_count;
            end
        end
    end

    // Sums are one bit wider than the coordinates, so they cannot overflow.
    always_comb begin
        x_sum      = {1'b0, snap_xmin} + {1'b0, snap_xmax};
        y_sum      = {1'b0, snap_ymin} + {1'b0, snap_ymax};
        snap_found = (snap_count >= MIN_LIMIT);
    end

    // Too-small frames still report their area but keep the old box.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_out     <= '0;
            y_out     <= '0;
            xmax_out  <= '0;
            ymax_out  <= '0;
            area_out  <= '0;
            found_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= snap_valid;
            if (snap_valid) begin
                area_out  <= snap_count;
                found_out <= snap_found;
                if (snap_found) begin
                    x_out    <= x_sum >> 1;
                    y_out    <= y_sum >> 1;
                    xmax_out <= {1'b0, snap_xmax};
                    ymax_out <= {1'b0, snap_ymax};
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_tracker.sv
// tb_bbox_tracker
// Directed, table-driven bench for bbox_tracker: each table row describes
// one frame's pixels and the result expected when that frame is published.
module tb_bbox_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        new_frame_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        mask_in;
    logic [11:0] x_out;
    logic [10:0] y_out;
    logic [11:0] xmax_out;
    logic [10:0] ymax_out;
    logic [20:0] area_out;
    logic        found_out;
    logic        valid_out;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        int x0, x1, y0, y1;
        bit offscreen;
        int ex, ey, exmax, eymax, earea;
        bit efound;
    } frame_vec_t;

    frame_vec_t vecs[7];

    bbox_tracker dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .new_frame_in(new_frame_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .mask_in(mask_in), .x_out(x_out),
        .y_out(y_out), .xmax_out(xmax_out), .ymax_out(ymax_out),
        .area_out(area_out), .found_out(found_out), .valid_out(valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic emit_pixel(input int h, input int v, input bit vld, input bit msk);
        valid_in  = vld;
        mask_in   = msk;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        @(posedge clk_in); #1;
        valid_in  = 1'b0;
        mask_in   = 1'b0;
    endtask

    task automatic emit_rect(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                emit_pixel(xx, yy, 1'b1, 1'b1);
    endtask

    // Pulse new_frame (optionally with a set pixel at (px,py)) and follow the
    // pipeline: valid_out must be low for two cycles and pulse on the third.
    task automatic pulse_frame(input string tag, input bit with_pix, input int px,
                               input int py, input bit expect_pub, input int ex,
                               input int ey, input int exmax, input int eymax,
                               input int earea, input bit efound);
        new_frame_in = 1'b1;
        valid_in     = with_pix;
        mask_in      = with_pix;
        hcount_in    = 11'(px);
        vcount_in    = 10'(py);
        @(posedge clk_in); #1;
        new_frame_in = 1'b0;
        valid_in     = 1'b0;
        mask_in      = 1'b0;
        check_output({tag, " valid_out t+1"}, 32'(valid_out), 0);
        @(posedge clk_in); #1;
        check_output({tag, " valid_out t+2"}, 32'(valid_out), 0);
        @(posedge clk_in); #1;
        check_output({tag, " valid_out t+3"}, 32'(valid_out), 32'(expect_pub));
        if (expect_pub) begin
            check_output({tag, " x_out"},     32'(x_out),     ex);
            check_output({tag, " y_out"},     32'(y_out),     ey);
            check_output({tag, " xmax_out"},  32'(xmax_out),  exmax);
            check_output({tag, " ymax_out"},  32'(ymax_out),  eymax);
            check_output({tag, " area_out"},  32'(area_out),  earea);
            check_output({tag, " found_out"}, 32'(found_out), 32'(efound));
        end
        @(posedge clk_in); #1;
        check_output({tag, " valid_out t+4"}, 32'(valid_out), 0);
    endtask

    // Frame content from one table row plus decoys that must never count.
    task automatic apply_stimulus(input int i);
        emit_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
        if (vecs[i].offscreen) begin
            emit_pixel(1300, 5, 1'b1, 1'b1);
            emit_pixel(5, 730, 1'b1, 1'b1);
        end
        emit_pixel(1000, 700, 1'b1, 1'b0);
        emit_pixel(1100, 600, 1'b0, 1'b1);
        pulse_frame($sformatf("vec%0d", i), 1'b0, 0, 0, 1'b1, vecs[i].ex, vecs[i].ey,
                    vecs[i].exmax, vecs[i].eymax, vecs[i].earea, vecs[i].efound);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " x_out"},     32'(x_out),     0);
        check_output({tag, " y_out"},     32'(y_out),     0);
        check_output({tag, " xmax_out"},  32'(xmax_out),  0);
        check_output({tag, " ymax_out"},  32'(ymax_out),  0);
        check_output({tag, " area_out"},  32'(area_out),  0);
        check_output({tag, " found_out"}, 32'(found_out), 0);
        check_output({tag, " valid_out"}, 32'(valid_out), 0);
    endtask

    initial begin
        //          x0    x1    y0   y1  off   ex    ey   exmax eymax area found
        vecs[0] = '{100,  199,  50,  89, 1'b0, 149,  69,  199,  89,  4000, 1'b1};
        vecs[1] = '{1,    0,    1,   0,  1'b0, 149,  69,  199,  89,  0,    1'b0};
        vecs[2] = '{300,  309,  400, 400, 1'b0, 149, 69,  199,  89,  10,   1'b0};
        vecs[3] = '{0,    15,   0,   0,  1'b1, 7,    0,   15,   0,   16,   1'b1};
        vecs[4] = '{1279, 1279, 704, 719, 1'b0, 1279, 711, 1279, 719, 16,  1'b1};
        vecs[5] = '{0,    14,   719, 719, 1'b0, 1279, 711, 1279, 719, 15,  1'b0};
        vecs[6] = '{1270, 1279, 710, 719, 1'b0, 1274, 714, 1279, 719, 100, 1'b1};

        rst_in       = 1'b1;
        valid_in     = 1'b0;
        new_frame_in = 1'b0;
        hcount_in    = '0;
        vcount_in    = '0;
        mask_in      = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;

        // First frame after reset is partial: no publish.
        pulse_frame("first", 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 7; i++) apply_stimulus(i);

        // Pixel coincident with new_frame belongs to the new frame.
        emit_rect(500, 519, 300, 300);
        pulse_frame("coinc_a", 1'b1, 0, 0, 1'b1, 509, 300, 519, 300, 20, 1'b1);
        emit_rect(1, 15, 0, 0);
        pulse_frame("coinc_b", 1'b0, 0, 0, 1'b1, 7, 0, 15, 0, 16, 1'b1);

        // Reset mid-frame discards the partial frame.
        emit_rect(600, 639, 100, 100);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check_all_zero("midrst");
        rst_in = 1'b0;
        emit_rect(0, 3, 500, 500);
        pulse_frame("rst_first", 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        emit_rect(700, 719, 10, 10);
        pulse_frame("rst_second", 1'b0, 0, 0, 1'b1, 709, 10, 719, 10, 20, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/bbox_tracker.md
Name: bbox_tracker

Overview:
- Consumes a per-pixel binary mask stream (e.g. colour-threshold output) tagged with hcount/vcount.
- Accumulates the bounding box of all set pixels over one frame.
- At each frame boundary, publishes the box in the centre/max form the block-sprite renderers consume: x = floor((xmin+xmax)/2) and xmax.
- Sits between the mask/threshold stage and the sprite overlay; it is the producer of the sprite coordinate inputs.

Parameters:
- H_ACTIVE, 1280, pixels per line; hcount_in >= H_ACTIVE is ignored.
- V_ACTIVE, 720, lines per frame; vcount_in >= V_ACTIVE is ignored.
- MIN_PIXELS, 16, minimum set-pixel count for a frame's box to be accepted.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  hcount_in/vcount_in/mask_in are valid this cycle.
- new_frame_in  input  1  one-cycle pulse coincident with the first pixel (0,0) of a frame; independent of valid_in.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- mask_in  input  1  pixel is part of the tracked object.
- x_out  output  12  floor((xmin+xmax)/2), zero-extended.
- y_out  output  11  floor((ymin+ymax)/2), zero-extended.
- xmax_out  output  12  rightmost set column, zero-extended.
- ymax_out  output  11  bottom set row, zero-extended.
- area_out  output  21  set-pixel count of the last published frame, saturating.
- found_out  output  1  last published frame met MIN_PIXELS.
- valid_out  output  1  one-cycle pulse when a result is published.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, found_out=0, valid_out=0, state=IDLE, accumulators cleared.
- Reset mid-frame: the partial frame is discarded and nothing is published.
- Stage 0: all inputs are registered (1 cycle).
- Stage 1: FSM plus accumulators act on the registered inputs.
- IDLE:
  - Ignores pixels.
  - On a registered new_frame, goes to ACCUM, seeds the accumulators from the same-cycle pixel, and does not publish. The first frame after reset is always partial.
- ACCUM, pixel qualifies when valid & mask & hcount<H_ACTIVE & vcount<V_ACTIVE:
  - xmin=min, xmax=max, ymin=min, ymax=max.
  - count += 1, saturating at 2^21-1.
- Accumulator empty state: xmin=all-ones, xmax=0, ymin=all-ones, ymax=0, count=0.
- ACCUM on registered new_frame:
  - Snapshot the accumulators into the result registers.
  - Re-seed the accumulators from that same cycle's pixel. A pixel coincident with new_frame belongs to the NEW frame.
  - Stay in ACCUM.
- Publish (1 cycle after the snapshot):
  - valid_out=1 for exactly one cycle.
  - area_out = snapshot count.
  - If count >= MIN_PIXELS: update all coordinate outputs, found_out=1.
  - Else: coordinate outputs hold their previous values, found_out=0.
- Latency: new_frame_in at cycle t -> valid_out and updated outputs at t+3 (input register, snapshot, publish register).
- Centre arithmetic: 12-bit sum (xmin+xmax), shift right 1, floor; likewise 11-bit for y. No overflow is possible at max widths.
- Back-to-back new_frame pulses: each publishes. An empty frame publishes area 0 with found_out=0.
- Outputs are stable between valid_out pulses.

Decomposition:
- Shared package (e.g. tracker_pkg):
  - Coordinate widths: HC_W=11, VC_W=10, XO_W=12, YO_W=11, AREA_W=21.
  - State enum {IDLE, ACCUM}.
  - Empty-accumulator constants.
- One natural sub-module: minmax_accum (parameterised width). Holds min/max registers with clear/seed/update inputs; instantiated for x and y.

Test Plan:
- Single frame, set pixels covering rectangle cols 100..199, rows 50..89 (4000 px). Next new_frame -> valid_out at t+3; x_out=149, xmax_out=199, y_out=69, ymax_out=89, area_out=4000, found_out=1.
- Empty frame after a valid frame -> area_out=0, found_out=0, coordinates hold 149/199/69/89, valid_out pulses once.
- 10 set pixels (< MIN_PIXELS=16) at cols 300..309, row 400 -> found_out=0, area_out=10, coordinates unchanged.
- Set pixels at hcount=1300 and vcount=730 plus one 16x1 run at cols 0..15, row 0 -> off-screen pixels ignored; xmax_out=15, x_out=7, ymax_out=0, area_out=16.
- new_frame_in coincident with mask pixel (0,0) -> that pixel is excluded from the published frame and included in the following frame's box.
- rst_in asserted mid-frame with pixels set -> all outputs 0 next cycle, no valid_out. First new_frame after reset gives no publish; the second publishes only pixels seen between them.
